// File: rtl/fifo_stream_arbiter.sv
// fifo_stream_arbiter
//   Packet-granular round-robin arbiter that shares one AXI-Stream FIFO write
//   port among NUM_SRC requesters. Whole packets are granted and the grant is
//   held until tlast. A packet is admitted only when the FIFO has at least
//   MAX_PKT free words, so a granted packet never stalls on FIFO full.
//   Packets longer than MAX_PKT beats are cut: tlast is forced on beat MAX_PKT
//   and trunc_err pulses once. The rest of that source's data then competes
//   for the port as a new packet.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-low reset
//   src_data   requester data, source i at [i*DATA_W +: DATA_W]
//   src_valid  requester tvalid
//   src_last   requester tlast
//   src_ready  requester tready
//   m_data     to FIFO s_data
//   m_valid    to FIFO s_valid
//   m_last     to FIFO s_last
//   m_ready    from FIFO s_ready
//   fifo_cnt   FIFO occupancy in words
//   grant      one-hot current owner, 0 when idle
//   busy       1 while a packet is being transferred
//   trunc_err  1-cycle pulse after a forced truncation
//   pkt_cnt    (only with FIFO_ARB_STATS_EN) per-source count of completed
//              packets, 16 bits per source, wrapping
//
// Configuration macro: FIFO_ARB_STATS_EN enables the pkt_cnt port and its counters.

module fifo_stream_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4096,
  parameter int MAX_PKT = 41,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  input  logic [CNT_W-1:0]          fifo_cnt,
  output logic [NUM_SRC-1:0]        grant,
  output logic                      busy,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_SRC*16-1:0]     pkt_cnt,
`endif
  output logic                      trunc_err
);

  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BEAT_W = $clog2(MAX_PKT + 1);
  localparam int FREE_W = CNT_W + 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand_idx;
  int                cand;
  logic              pick_found;
  logic [BEAT_W-1:0] beat_cnt;
  logic [FREE_W-1:0] free_words;
  logic              space_ok;
  logic [DATA_W-1:0] cur_data;
  logic              cur_valid;
  logic              cur_last;
  logic              at_max;
  logic              beat;
  logic              end_pkt;
  logic              force_trunc;

  // An occupancy above DEPTH is treated as "no space" so that the
  // unsigned subtraction can never wrap into a large free count.
  always_comb begin
    free_words = FREE_W'(DEPTH) - FREE_W'(fifo_cnt);
    space_ok   = (FREE_W'(fifo_cnt) <= FREE_W'(DEPTH)) &&
                 (free_words >= FREE_W'(MAX_PKT));
  end

  // Round-robin search starting one past the last owner.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand     = (int'(rr_ptr) + k) % NUM_SRC;
      cand_idx = IDX_W'(cand);
      if (!pick_found && src_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Granted-source mux and beat/end-of-packet qualifiers.
  always_comb begin
    cur_data    = src_data[gnt_idx*DATA_W +: DATA_W];
    cur_valid   = src_valid[gnt_idx];
    cur_last    = src_last[gnt_idx];
    at_max      = (beat_cnt == BEAT_W'(MAX_PKT - 1));
    beat        = (state == XFER) && cur_valid && m_ready;
    end_pkt     = beat && (cur_last || at_max);
    force_trunc = beat && at_max && !cur_last;
  end

  // Outputs are a pure pass-through of the owner while in XFER. In IDLE
  // every output is held at zero, which gives the one-cycle bubble
  // between packets.
  always_comb begin
    m_data    = '0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    src_ready = '0;
    grant     = '0;
    busy      = 1'b0;
    if (state == XFER) begin
      m_data             = cur_data;
      m_valid            = cur_valid;
      m_last             = cur_valid && (cur_last || at_max);
      src_ready[gnt_idx] = m_ready;
      grant[gnt_idx]     = 1'b1;
      busy               = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (space_ok && pick_found) state_nxt = XFER;
      XFER:    if (end_pkt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rr_ptr resets to the last source so that the first grant goes to source 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      rr_ptr    <= IDX_W'(NUM_SRC - 1);
      beat_cnt  <= '0;
      trunc_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      trunc_err <= force_trunc;
      if (state == IDLE) begin
        if (space_ok && pick_found) begin
          gnt_idx <= pick_idx;
        end
      end else if (beat) begin
        if (end_pkt) begin
          rr_ptr   <= gnt_idx;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_cnt [NUM_SRC];

  // Counts both natural and truncated packet completions; wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        stat_cnt[i] <= '0;
      end
    end else if (end_pkt) begin
      stat_cnt[gnt_idx] <= stat_cnt[gnt_idx] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_stat
    assign pkt_cnt[gi*16 +: 16] = stat_cnt[gi];
  end
`endif

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// tb_fifo_stream_arbiter
//   Scoreboard bench for fifo_stream_arbiter (NUM_SRC=4, DATA_W=32,
//   DEPTH=4096, MAX_PKT=41). Per-source queues feed the requesters. Expected
//   FIFO-side beats are queued in grant order and compared as they appear.
//   Build with +define+FIFO_ARB_STATS_EN to also check pkt_cnt.

module tb_fifo_stream_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4096;
  localparam int MAX_PKT = 41;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
    logic        last;
    logic        trunc;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_SRC*DATA_W-1:0] src_data = '0;
  logic [NUM_SRC-1:0]        src_valid = '0;
  logic [NUM_SRC-1:0]        src_last = '0;
  logic [NUM_SRC-1:0]        src_ready;
  logic [DATA_W-1:0]         m_data;
  logic                      m_valid;
  logic                      m_last;
  logic                      m_ready = 1'b1;
  logic [CNT_W-1:0]          fifo_cnt = '0;
  logic [NUM_SRC-1:0]        grant;
  logic                      busy;
  logic                      trunc_err;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_SRC*16-1:0]     pkt_cnt;
`endif

  beat_t src_q [NUM_SRC][$];
  exp_t  exp_q [$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit ready_mode = 1'b0;
  bit gap_mode = 1'b0;
  bit trunc_pend = 1'b0;
  bit last_prev = 1'b0;

  fifo_stream_arbiter #(
    .NUM_SRC(NUM_SRC),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .MAX_PKT(MAX_PKT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_data (src_data),
    .src_valid(src_valid),
    .src_last (src_last),
    .src_ready(src_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .fifo_cnt (fifo_cnt),
    .grant    (grant),
    .busy     (busy),
`ifdef FIFO_ARB_STATS_EN
    .pkt_cnt  (pkt_cnt),
`endif
    .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] word(input int src, input int tag, input int b);
    return {8'(tag), 8'(src), 16'(b)};
  endfunction

  task automatic applyStimulus(input int src, input int len, input int tag);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = word(src, tag, k);
      b.last = (k == len - 1);
      src_q[src].push_back(b);
    end
  endtask

  // Expected FIFO-side view of one source packet: it is split every
  // MAX_PKT beats, and each forced split raises trunc.
  task automatic expectPacket(input int src, input int len, input int tag);
    exp_t e;
    int   inchunk;
    inchunk = 0;
    for (int k = 0; k < len; k++) begin
      inchunk++;
      e.src   = 2'(src);
      e.data  = word(src, tag, k);
      e.last  = (k == len - 1) || (inchunk == MAX_PKT);
      e.trunc = (inchunk == MAX_PKT) && (k != len - 1);
      if (e.last) inchunk = 0;
      exp_q.push_back(e);
    end
  endtask

  function automatic bit anySrc();
    bit r;
    r = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) if (src_q[i].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic sampleOutputs();
    exp_t e;
    checkOutput("trunc_err", 64'(trunc_err), 64'(trunc_pend));
    trunc_pend = 1'b0;
    if (last_prev) checkOutput("bubble_busy", 64'(busy), 64'd0);
    last_prev = 1'b0;
    if (!m_valid) checkOutput("m_last_idle", 64'(m_last), 64'd0);
    if (busy && !m_ready) checkOutput("ready_mirror", 64'(src_ready), 64'd0);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 64'(m_data), 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("m_data", 64'(m_data), 64'(e.data));
        checkOutput("m_last", 64'(m_last), 64'(e.last));
        checkOutput("grant", 64'(grant), 64'(4'b0001 << e.src));
        checkOutput("src_ready", 64'(src_ready), 64'(4'b0001 << e.src));
        trunc_pend = e.trunc;
        last_prev  = e.last;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && src_ready[i]) void'(src_q[i].pop_front());
    end
  endtask

  task automatic runCycles(input int n);
    bit gap;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NUM_SRC; i++) begin
        gap = gap_mode && ($urandom_range(0, 3) == 0);
        if (src_q[i].size() > 0 && !gap) begin
          src_valid[i]             = 1'b1;
          src_data[i*32 +: 32]     = src_q[i][0].data;
          src_last[i]              = src_q[i][0].last;
        end else begin
          src_valid[i]             = 1'b0;
          src_data[i*32 +: 32]     = '0;
          src_last[i]              = 1'b0;
        end
      end
      m_ready = !ready_mode || (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      sampleOutputs();
    end
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || anySrc()) && n < budget) begin
      runCycles(1);
      n++;
    end
    checkOutput("drain_timeout", 64'(exp_q.size() > 0 || anySrc()), 64'd0);
    runCycles(2);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_grant"}, 64'(grant), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    checkOutput({tag, "_m_last"}, 64'(m_last), 64'd0);
    checkOutput({tag, "_m_data"}, 64'(m_data), 64'd0);
    checkOutput({tag, "_src_ready"}, 64'(src_ready), 64'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    runCycles(2);
    checkResetOutputs("reset");
    rst = 1'b1;

    // Reset in the middle of a packet drops it at once.
    applyStimulus(2, 41, 1);
    expectPacket(2, 41, 1);
    runCycles(8);
    checkOutput("pre_rst_grant", 64'(grant), 64'(4'b0100));
    #2 rst = 1'b0;
    #1 checkResetOutputs("midrst");
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    exp_q.delete();
    trunc_pend = 1'b0;
    last_prev  = 1'b0;
    runCycles(2);
    rst = 1'b1;

    // All four sources contend: strict rotation starting at source 0.
    for (int s = 0; s < NUM_SRC; s++) applyStimulus(s, 41, 2);
    applyStimulus(0, 41, 3);
    for (int s = 0; s < NUM_SRC; s++) expectPacket(s, 41, 2);
    expectPacket(0, 41, 3);
    waitDrain(400);

    // Admission threshold: full, 40 free (blocked), 41 free (admitted).
    fifo_cnt = CNT_W'(DEPTH);
    applyStimulus(2, 5, 4);
    expectPacket(2, 5, 4);
    runCycles(3);
    checkOutput("full_grant", 64'(grant), 64'd0);
    fifo_cnt = CNT_W'(4056);
    runCycles(3);
    checkOutput("free40_grant", 64'(grant), 64'd0);
    checkOutput("free40_busy", 64'(busy), 64'd0);
    fifo_cnt = CNT_W'(4055);
    runCycles(1);
    checkOutput("free41_grant", 64'(grant), 64'(4'b0100));
    fifo_cnt = CNT_W'(DEPTH);
    waitDrain(50);
    fifo_cnt = '0;

    // A 50-beat packet is cut at 41 and the tail is sent as a new packet.
    gap_mode = 1'b1;
    applyStimulus(1, 50, 5);
    expectPacket(1, 50, 5);
    waitDrain(400);
    gap_mode = 1'b0;

    rst = 1'b0;
    runCycles(1);
    checkResetOutputs("rst2");
    rst = 1'b1;

    // Backpressure pattern 1,0,0,1 while sources 0 and 3 alternate.
    ready_mode = 1'b1;
    applyStimulus(0, 5, 6);
    applyStimulus(0, 6, 7);
    applyStimulus(0, 7, 8);
    applyStimulus(3, 4, 9);
    applyStimulus(3, 9, 10);
    expectPacket(0, 5, 6);
    expectPacket(3, 4, 9);
    expectPacket(0, 6, 7);
    expectPacket(3, 9, 10);
    expectPacket(0, 7, 8);
    waitDrain(400);
    ready_mode = 1'b0;

`ifdef FIFO_ARB_STATS_EN
    checkOutput("pkt_cnt0", 64'(pkt_cnt[15:0]), 64'd3);
    checkOutput("pkt_cnt1", 64'(pkt_cnt[31:16]), 64'd0);
    checkOutput("pkt_cnt2", 64'(pkt_cnt[47:32]), 64'd0);
    checkOutput("pkt_cnt3", 64'(pkt_cnt[63:48]), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
